// File: rtl/hms_timer_pkg.sv
// Shared constants, time record type and BCD helpers for the HH:MM:SS timer.
package hms_timer_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int BCD_W   = 8;

    typedef struct packed {
        logic [6:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // Both nibbles are widened before the multiply so 15*10+15 cannot overflow.
    function automatic logic [7:0] bcd2bin8(input logic [BCD_W-1:0] b);
        return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
    endfunction

endpackage

// File: rtl/hms_bin2bcd.sv
// Binary to two-digit BCD for values 0..99.
module hms_bin2bcd #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_bin,
    output logic [7:0]   o_bcd
);

    assign o_bcd = {4'(i_bin / W'(10)), 4'(i_bin % W'(10))};

endmodule

// File: rtl/hms_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal count as a tick.
module hms_tick_gen #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_restart,
    output logic o_tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hms_updown_timer.sv
// HH:MM:SS timer: wrapping wall clock when counting up, halting countdown with expiry flag when counting down.
module hms_updown_timer
    import hms_timer_pkg::*;
#(
    parameter int FREQUENCY_IN = 100_000_000,
    parameter int TICK_HZ      = 1,
    parameter int HOUR_MODULO  = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_in,
    input  logic       dir_in,
    input  logic       clear_in,
    input  logic       load_in,
    input  logic [7:0] loadBcdHour_in,
    input  logic [7:0] loadBcdMinute_in,
    input  logic [7:0] loadBcdSecond_in,
    output logic [7:0] bcdHour_out,
    output logic [7:0] bcdMinute_out,
    output logic [7:0] bcdSecond_out,
    output logic       tick_out,
    output logic       rollover_out,
    output logic       done_out,
    output logic       expired_out,
    output logic       loadErr_out
);

    localparam int         DIV       = FREQUENCY_IN / TICK_HZ;
    localparam logic [6:0] HOUR_LAST = 7'(HOUR_MODULO - 1);

    hms_t r_time;
    logic r_tick, r_roll, r_done, r_expired, r_load_err;

    logic       w_tick, w_restart, w_zero, w_apply, w_load_ok, w_wrap;
    logic [7:0] w_ld_hour, w_ld_min, w_ld_sec;
    hms_t       w_next_up, w_next_down;

    assign w_restart = clear_in | load_in;

    hms_tick_gen #(.DIV(DIV)) u_tick_gen (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_en      (en_in),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // A countdown parked at zero swallows ticks entirely, so no done_out is raised from a zero start.
    assign w_zero  = (r_time == '0);
    assign w_apply = w_tick && !w_restart && !(w_zero && !dir_in);

    assign w_ld_hour = bcd2bin8(loadBcdHour_in);
    assign w_ld_min  = bcd2bin8(loadBcdMinute_in);
    assign w_ld_sec  = bcd2bin8(loadBcdSecond_in);
    assign w_load_ok = bcd_valid(loadBcdHour_in) && bcd_valid(loadBcdMinute_in) &&
                       bcd_valid(loadBcdSecond_in) &&
                       (w_ld_min <= 8'(MIN_MAX)) && (w_ld_sec <= 8'(SEC_MAX)) &&
                       (w_ld_hour < 8'(HOUR_MODULO));

    always_comb begin
        w_next_up = r_time;
        w_wrap    = 1'b0;
        if (r_time.sec == 6'(SEC_MAX)) begin
            w_next_up.sec = '0;
            if (r_time.min == 6'(MIN_MAX)) begin
                w_next_up.min = '0;
                if (r_time.hour == HOUR_LAST) begin
                    w_next_up.hour = '0;
                    w_wrap         = 1'b1;
                end else begin
                    w_next_up.hour = r_time.hour + 7'd1;
                end
            end else begin
                w_next_up.min = r_time.min + 6'd1;
            end
        end else begin
            w_next_up.sec = r_time.sec + 6'd1;
        end
    end

    // Only evaluated when the time is non-zero, so the hour borrow never underflows.
    always_comb begin
        w_next_down = r_time;
        if (r_time.sec == '0) begin
            w_next_down.sec = 6'(SEC_MAX);
            if (r_time.min == '0) begin
                w_next_down.min  = 6'(MIN_MAX);
                w_next_down.hour = r_time.hour - 7'd1;
            end else begin
                w_next_down.min = r_time.min - 6'd1;
            end
        end else begin
            w_next_down.sec = r_time.sec - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        r_tick     <= 1'b0;
        r_roll     <= 1'b0;
        r_done     <= 1'b0;
        r_load_err <= 1'b0;
        if (!rst) begin
            r_time    <= '0;
            r_expired <= 1'b0;
        end else if (clear_in) begin
            r_time    <= '0;
            r_expired <= 1'b0;
        end else if (load_in) begin
            if (w_load_ok) begin
                r_time.hour <= w_ld_hour[6:0];
                r_time.min  <= w_ld_min[5:0];
                r_time.sec  <= w_ld_sec[5:0];
                r_expired   <= 1'b0;
            end else begin
                r_load_err <= 1'b1;
                if (dir_in) r_expired <= 1'b0;
            end
        end else begin
            if (dir_in) r_expired <= 1'b0;
            if (w_apply) begin
                r_tick <= 1'b1;
                if (dir_in) begin
                    r_time <= w_next_up;
                    r_roll <= w_wrap;
                end else begin
                    r_time <= w_next_down;
                    if (w_next_down == '0) begin
                        r_done    <= 1'b1;
                        r_expired <= 1'b1;
                    end
                end
            end
        end
    end

    hms_bin2bcd #(.W(7)) u_bcd_hour (.i_bin(r_time.hour), .o_bcd(bcdHour_out));
    hms_bin2bcd #(.W(6)) u_bcd_min  (.i_bin(r_time.min),  .o_bcd(bcdMinute_out));
    hms_bin2bcd #(.W(6)) u_bcd_sec  (.i_bin(r_time.sec),  .o_bcd(bcdSecond_out));

    assign tick_out     = r_tick;
    assign rollover_out = r_roll;
    assign done_out     = r_done;
    assign expired_out  = r_expired;
    assign loadErr_out  = r_load_err;

endmodule

// File: tb/tb_hms_updown_timer.sv
// Directed bench for hms_updown_timer with DIV=4; a 12-hour instance shares the stimulus for the wrap check.
module tb_hms_updown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_in = 1'b0;
    logic       dir_in = 1'b1;
    logic       clear_in = 1'b0;
    logic       load_in = 1'b0;
    logic [7:0] ld_h = 8'h00;
    logic [7:0] ld_m = 8'h00;
    logic [7:0] ld_s = 8'h00;

    logic [7:0] hour_24, min_24, sec_24, hour_12, min_12, sec_12;
    logic       tick_24, roll_24, done_24, exp_24, lerr_24;
    logic       tick_12, roll_12, done_12, exp_12, lerr_12;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tick   = 0;
    int n_roll   = 0;
    int n_roll12 = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    hms_updown_timer #(.FREQUENCY_IN(4), .TICK_HZ(1), .HOUR_MODULO(24)) dut (
        .clk(clk), .rst(rst), .en_in(en_in), .dir_in(dir_in),
        .clear_in(clear_in), .load_in(load_in),
        .loadBcdHour_in(ld_h), .loadBcdMinute_in(ld_m), .loadBcdSecond_in(ld_s),
        .bcdHour_out(hour_24), .bcdMinute_out(min_24), .bcdSecond_out(sec_24),
        .tick_out(tick_24), .rollover_out(roll_24), .done_out(done_24),
        .expired_out(exp_24), .loadErr_out(lerr_24)
    );

    hms_updown_timer #(.FREQUENCY_IN(4), .TICK_HZ(1), .HOUR_MODULO(12)) dut12 (
        .clk(clk), .rst(rst), .en_in(en_in), .dir_in(dir_in),
        .clear_in(clear_in), .load_in(load_in),
        .loadBcdHour_in(ld_h), .loadBcdMinute_in(ld_m), .loadBcdSecond_in(ld_s),
        .bcdHour_out(hour_12), .bcdMinute_out(min_12), .bcdSecond_out(sec_12),
        .tick_out(tick_12), .rollover_out(roll_12), .done_out(done_12),
        .expired_out(exp_12), .loadErr_out(lerr_12)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        n_tick   = 0;
        n_roll   = 0;
        n_roll12 = 0;
        n_done   = 0;
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_tick   += int'(tick_24);
            n_roll   += int'(roll_24);
            n_roll12 += int'(roll_12);
            n_done   += int'(done_24);
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ld_h    = h;
        ld_m    = m;
        ld_s    = s;
        load_in = 1'b1;
        run_edges(1);
        load_in = 1'b0;
    endtask

    function automatic logic [31:0] t24();
        return {8'h00, hour_24, min_24, sec_24};
    endfunction

    function automatic logic [31:0] t12();
        return {8'h00, hour_12, min_12, sec_12};
    endfunction

    initial begin
        // Reset state
        run_edges(2);
        check_eq("rst_time", t24(), 32'h000000);
        check_eq("rst_tick", tick_24, 1'b0);
        check_eq("rst_roll", roll_24, 1'b0);
        check_eq("rst_done", done_24, 1'b0);
        check_eq("rst_exp", exp_24, 1'b0);
        check_eq("rst_lerr", lerr_24, 1'b0);

        // Free-running up count: ticks land on every fourth edge
        rst    = 1'b1;
        en_in  = 1'b1;
        dir_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check_eq("t1_tick", tick_24, (i % 4 == 3) ? 1'b1 : 1'b0);
        end
        check_eq("t1_time", t24(), 32'h000002);
        check_eq("t1_flags", {roll_24, done_24, exp_24, lerr_24}, 4'b0000);

        // Wrap 23:59:58 -> 00:00:00
        do_load(8'h23, 8'h59, 8'h58);
        check_eq("t2_load", t24(), 32'h235958);
        clr_counts();
        run_edges(4);
        check_eq("t2_t1", t24(), 32'h235959);
        check_eq("t2_roll0", n_roll, 0);
        run_edges(4);
        check_eq("t2_wrap", t24(), 32'h000000);
        check_eq("t2_roll1", n_roll, 1);

        // 11:59:59 wraps on the 12-hour build, carries on the 24-hour build
        do_load(8'h11, 8'h59, 8'h59);
        clr_counts();
        run_edges(4);
        check_eq("t2_12_wrap", t12(), 32'h000000);
        check_eq("t2_12_roll", n_roll12, 1);
        check_eq("t2_24_carry", t24(), 32'h120000);
        check_eq("t2_24_roll", n_roll, 0);

        // Countdown to zero then halt
        dir_in = 1'b0;
        do_load(8'h00, 8'h00, 8'h02);
        clr_counts();
        run_edges(8);
        check_eq("t3_time", t24(), 32'h000000);
        check_eq("t3_done", n_done, 1);
        check_eq("t3_ticks", n_tick, 2);
        check_eq("t3_exp", exp_24, 1'b1);
        clr_counts();
        run_edges(12);
        check_eq("t3_hold_ticks", n_tick, 0);
        check_eq("t3_hold_done", n_done, 0);
        check_eq("t3_hold_time", t24(), 32'h000000);
        check_eq("t3_hold_exp", exp_24, 1'b1);

        // Rejected loads
        do_load(8'h00, 8'h00, 8'h1A);
        check_eq("t4_sec_err", lerr_24, 1'b1);
        check_eq("t4_sec_time", t24(), 32'h000000);
        check_eq("t4_sec_exp", exp_24, 1'b1);
        run_edges(1);
        check_eq("t4_err_pulse", lerr_24, 1'b0);
        en_in = 1'b0;
        do_load(8'h01, 8'h02, 8'h03);
        check_eq("t4_ok_time", t24(), 32'h010203);
        check_eq("t4_ok_exp", exp_24, 1'b0);
        check_eq("t4_ok_err", lerr_24, 1'b0);
        do_load(8'h00, 8'h60, 8'h00);
        check_eq("t4_min_err", lerr_24, 1'b1);
        check_eq("t4_min_time", t24(), 32'h010203);
        do_load(8'h24, 8'h00, 8'h00);
        check_eq("t4_hour_err", lerr_24, 1'b1);
        check_eq("t4_hour_time", t24(), 32'h010203);

        // clear_in and load_in together on a tick edge
        en_in  = 1'b1;
        dir_in = 1'b1;
        do_load(8'h05, 8'h00, 8'h00);
        clr_counts();
        run_edges(3);
        check_eq("t5_pre_ticks", n_tick, 0);
        ld_h     = 8'h07;
        ld_m     = 8'h07;
        ld_s     = 8'h07;
        clear_in = 1'b1;
        load_in  = 1'b1;
        run_edges(1);
        clear_in = 1'b0;
        load_in  = 1'b0;
        check_eq("t5_time", t24(), 32'h000000);
        check_eq("t5_no_tick", n_tick, 0);
        run_edges(3);
        check_eq("t5_restart_wait", n_tick, 0);
        run_edges(1);
        check_eq("t5_restart_tick", n_tick, 1);
        check_eq("t5_restart_time", t24(), 32'h000001);

        // Reset while expired, then exact prescaler freeze
        dir_in = 1'b0;
        do_load(8'h00, 8'h00, 8'h01);
        clr_counts();
        run_edges(4);
        check_eq("t6_done", n_done, 1);
        check_eq("t6_exp", exp_24, 1'b1);
        run_edges(2);
        rst = 1'b0;
        run_edges(1);
        rst = 1'b1;
        check_eq("t6_rst_time", t24(), 32'h000000);
        check_eq("t6_rst_exp", exp_24, 1'b0);
        clr_counts();
        run_edges(8);
        check_eq("t6_zero_ticks", n_tick, 0);
        check_eq("t6_zero_done", n_done, 0);
        check_eq("t6_zero_exp", exp_24, 1'b0);
        dir_in = 1'b1;
        run_edges(2);
        en_in = 1'b0;
        run_edges(5);
        check_eq("t6_frz_ticks", n_tick, 0);
        check_eq("t6_frz_time", t24(), 32'h000000);
        en_in = 1'b1;
        run_edges(1);
        check_eq("t6_resume_wait", n_tick, 0);
        run_edges(1);
        check_eq("t6_resume_tick", n_tick, 1);
        check_eq("t6_resume_time", t24(), 32'h000001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
